// File: rtl/keypad_scanner_pkg.sv
// Shared sizes, reset constants and FSM encoding for the 4x4 keypad scanner.
package keypad_scanner_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned MAP_W    = NUM_ROWS * NUM_COLS;
  localparam int unsigned KEY_W    = 4;
  localparam int unsigned COL_W    = 2;
  localparam int unsigned CNT_W    = 4;

  localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LOCKED  = 2'd2
  } key_state_e;

  typedef logic [MAP_W-1:0] key_map_t;

  // Index of the highest set bit; only meaningful for a one-hot map.
  function automatic logic [KEY_W-1:0] key_index(input key_map_t map);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAP_W); i++) begin
      if (map[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad row lines.
module row_sync
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned WIDTH = NUM_ROWS
) (
  input  logic             i_clk,
  input  logic             i_rst_l,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta;

  // Idle rows read high, so both stages reset to all ones.
  always_ff @(posedge i_clk) begin
    if (!i_rst_l) begin
      meta <= '1;
      o_q  <= '1;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walking-zero column drive, frame debounce,
// single-key acceptance with multi-key lockout.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_l,
  input  logic                i_tick,
  input  logic [NUM_ROWS-1:0] i_row_l,
  output logic [NUM_COLS-1:0] o_col_l,
  output logic [KEY_W-1:0]    o_key,
  output logic                o_key_valid,
  output logic                o_key_held
);

  localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  logic [NUM_ROWS-1:0] row_sync_l;
  logic [COL_W-1:0]    col_idx;
  key_map_t            acc_map;
  key_map_t            prev_map;
  key_map_t            frame_map_c;
  logic [CNT_W-1:0]    stable_cnt;
  logic [CNT_W-1:0]    stable_cnt_c;
  logic                frame_close_c;
  logic                debounced_c;
  key_state_e          state;
  key_state_e          state_next;
  logic [KEY_W-1:0]    key_next;
  logic                key_valid_next;

  row_sync #(
    .WIDTH (NUM_ROWS)
  ) u_row_sync (
    .i_clk   (i_clk),
    .i_rst_l (i_rst_l),
    .i_d     (i_row_l),
    .o_q     (row_sync_l)
  );

  // Overlay the rows seen on the driven column onto the frame being built.
  always_comb begin
    frame_map_c = acc_map;
    for (int r = 0; r < int'(NUM_ROWS); r++) begin
      for (int c = 0; c < int'(NUM_COLS); c++) begin
        if (COL_W'(c) == col_idx) begin
          frame_map_c[r*int'(NUM_COLS) + c] = ~row_sync_l[r];
        end
      end
    end
  end

  // Run length of identical frames, saturating at the debounce depth.
  always_comb begin
    frame_close_c = i_tick && (col_idx == LAST_COL);
    if (frame_map_c != prev_map) begin
      stable_cnt_c = CNT_W'(1);
    end else if (stable_cnt >= DEB_CNT) begin
      stable_cnt_c = DEB_CNT;
    end else begin
      stable_cnt_c = stable_cnt + CNT_W'(1);
    end
    debounced_c = frame_close_c && (stable_cnt_c == DEB_CNT);
  end

  // Column walk, frame accumulation and frame-to-frame history.
  always_ff @(posedge i_clk) begin
    if (!i_rst_l) begin
      o_col_l    <= COL_RESET;
      col_idx    <= '0;
      acc_map    <= '0;
      prev_map   <= '0;
      stable_cnt <= '0;
    end else if (i_tick) begin
      o_col_l <= {o_col_l[NUM_COLS-2:0], o_col_l[NUM_COLS-1]};
      col_idx <= col_idx + COL_W'(1);
      acc_map <= frame_map_c;
      if (frame_close_c) begin
        prev_map   <= frame_map_c;
        stable_cnt <= stable_cnt_c;
      end
    end
  end

  // Key FSM state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_l) begin
      state       <= ST_IDLE;
      o_key       <= '0;
      o_key_valid <= 1'b0;
      o_key_held  <= 1'b0;
    end else begin
      state       <= state_next;
      o_key       <= key_next;
      o_key_valid <= key_valid_next;
      o_key_held  <= (state_next == ST_PRESSED);
    end
  end

  // Decisions are only taken on a debounced frame close.
  always_comb begin
    state_next     = state;
    key_next       = o_key;
    key_valid_next = 1'b0;
    if (debounced_c) begin
      case (state)
        ST_IDLE: begin
          if ($onehot(frame_map_c)) begin
            state_next     = ST_PRESSED;
            key_next       = key_index(frame_map_c);
            key_valid_next = 1'b1;
          end else if (frame_map_c != '0) begin
            state_next = ST_LOCKED;
          end
        end
        ST_PRESSED, ST_LOCKED: begin
          if (frame_map_c == '0) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, frame-history reference, directed tables, random runs.
module tb_keypad_scanner;

  localparam int unsigned DEB = 3;
  localparam int M_IDLE = 0;
  localparam int M_PRESSED = 1;
  localparam int M_LOCKED = 2;

  logic       i_clk = 1'b0;
  logic       i_rst_l;
  logic       i_tick;
  logic [3:0] i_row_l;
  logic [3:0] o_col_l;
  logic [3:0] o_key;
  logic       o_key_valid;
  logic       o_key_held;

  logic [15:0] keys;
  int total = 0;
  int bad = 0;
  int pulses = 0;
  bit chk_en = 1'b0;
  logic prev_valid = 1'b0;

  // reference model state
  int          m_col;
  logic [15:0] m_acc;
  logic [15:0] m_frames[$];
  int          m_state;
  logic [3:0]  m_key;
  logic        m_valid;
  logic [3:0]  m_hist0, m_hist1;
  logic [3:0]  m_row_now;
  logic [15:0] m_cur;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          exp_pulses;
    logic [3:0]  exp_key;
    logic        exp_held;
  } vec_t;

  vec_t vecs[$];

  keypad_scanner #(.DEBOUNCE_FRAMES(DEB)) dut (
    .i_clk       (i_clk),
    .i_rst_l     (i_rst_l),
    .i_tick      (i_tick),
    .i_row_l     (i_row_l),
    .o_col_l     (o_col_l),
    .o_key       (o_key),
    .o_key_valid (o_key_valid),
    .o_key_held  (o_key_held)
  );

  always #5 i_clk = ~i_clk;

  // Physical keypad: a pressed key shorts its row to its column when driven low.
  always_comb begin
    i_row_l = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!o_col_l[c] && keys[4*r+c]) i_row_l[r] = 1'b0;
  end

  function automatic logic [3:0] rows_for(input logic [15:0] k, input int col);
    logic [3:0] rr;
    rr = 4'hF;
    for (int r = 0; r < 4; r++) if (k[4*r+col]) rr[r] = 1'b0;
    return rr;
  endfunction

  function automatic bit m_debounced();
    if (m_frames.size() < DEB) return 1'b0;
    foreach (m_frames[i]) if (m_frames[i] != m_frames[m_frames.size()-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: rows reach the sampler two edges late; a frame is the 16 samples
  // between col-3 ticks; the map is debounced once the last DEB frames agree.
  always @(posedge i_clk) begin
    m_row_now = rows_for(keys, m_col);
    m_valid = 1'b0;
    if (!i_rst_l) begin
      m_col = 0; m_acc = '0; m_frames.delete();
      m_state = M_IDLE; m_key = '0;
      m_hist0 = 4'hF; m_hist1 = 4'hF;
    end else begin
      if (i_tick) begin
        for (int r = 0; r < 4; r++) m_acc[4*r+m_col] = ~m_hist1[r];
        if (m_col == 3) begin
          m_frames.push_back(m_acc);
          if (m_frames.size() > DEB) void'(m_frames.pop_front());
          if (m_debounced()) begin
            m_cur = m_acc;
            if (m_state == M_IDLE) begin
              if ($countones(m_cur) == 1) begin
                m_state = M_PRESSED;
                for (int b = 0; b < 16; b++) if (m_cur[b]) m_key = 4'(b);
                m_valid = 1'b1;
              end else if ($countones(m_cur) > 1) begin
                m_state = M_LOCKED;
              end
            end else if (m_cur == 16'h0) begin
              m_state = M_IDLE;
            end
          end
        end
        m_col = (m_col + 1) % 4;
      end
      m_hist1 = m_hist0;
      m_hist0 = m_row_now;
    end
  end

  // Cycle-by-cycle comparison against the reference, away from the active edge.
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("no_x", 32'($isunknown({o_col_l, o_key, o_key_valid, o_key_held})), 32'd0);
      chk("col", 32'(o_col_l), 32'(4'hF ^ (4'h1 << m_col)));
      chk("key", 32'(o_key), 32'(m_key));
      chk("valid", 32'(o_key_valid), 32'(m_valid));
      chk("held", 32'(o_key_held), 32'(m_state == M_PRESSED));
      chk("valid_gap", 32'(o_key_valid & prev_valid), 32'd0);
      if (o_key_valid === 1'b1) pulses++;
      prev_valid = o_key_valid;
    end
  end

  task automatic tick_after(input int gap);
    repeat (gap) @(posedge i_clk);
    #1 i_tick = 1'b1;
    @(posedge i_clk);
    #1 i_tick = 1'b0;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < 4*n; i++) tick_after(3);
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int p0;
    p0 = pulses;
    keys = v.keys;
    run_frames(v.frames);
    chk({name, "_pulses"}, 32'(pulses - p0), 32'(v.exp_pulses));
    chk({name, "_key"}, 32'(o_key), 32'(v.exp_key));
    chk({name, "_held"}, 32'(o_key_held), 32'(v.exp_held));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] col_seq [8];
    int p0;
    col_seq = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};

    i_rst_l = 1'b0; i_tick = 1'b0; keys = '0;
    repeat (3) @(posedge i_clk);
    #1 chk_en = 1'b1;
    i_rst_l = 1'b1;

    // Column walk after reset with no keys.
    for (int i = 0; i < 8; i++) begin
      chk("col_walk", 32'(o_col_l), 32'(col_seq[i]));
      chk("walk_quiet", 32'({o_key, o_key_valid, o_key_held}), 32'd0);
      tick_after(3);
    end
    chk("walk_wrap", 32'(o_col_l), 32'(4'hE));

    // Directed frame tables.
    vecs.push_back('{16'h0000, 1, 0, 4'd0, 1'b0});
    vecs.push_back('{16'h0040, 2, 0, 4'd0, 1'b0});
    vecs.push_back('{16'h0040, 1, 1, 4'd6, 1'b1});
    vecs.push_back('{16'h0040, 3, 0, 4'd6, 1'b1});
    vecs.push_back('{16'h0000, 2, 0, 4'd6, 1'b1});
    vecs.push_back('{16'h0000, 1, 0, 4'd6, 1'b0});
    for (int i = 0; i < 6; i++)
      vecs.push_back('{(i % 2 == 0) ? 16'h0001 : 16'h0000, 1, 0, 4'd6, 1'b0});
    vecs.push_back('{16'h0001, 2, 0, 4'd6, 1'b0});
    vecs.push_back('{16'h0001, 1, 1, 4'd0, 1'b1});
    vecs.push_back('{16'h0000, 3, 0, 4'd0, 1'b0});
    vecs.push_back('{16'h0021, 4, 0, 4'd0, 1'b0});
    vecs.push_back('{16'h0000, 3, 0, 4'd0, 1'b0});
    vecs.push_back('{16'h8000, 3, 1, 4'd15, 1'b1});
    vecs.push_back('{16'h0000, 3, 0, 4'd15, 1'b0});
    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset while a key is held: press is abandoned, then re-detected.
    run_vec("k9_press", '{16'h0200, 3, 1, 4'd9, 1'b1});
    #1 i_rst_l = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_col", 32'(o_col_l), 32'(4'hE));
    chk("rst_outs", 32'({o_key, o_key_valid, o_key_held}), 32'd0);
    i_rst_l = 1'b1;
    run_vec("k9_again", '{16'h0200, 3, 1, 4'd9, 1'b1});
    run_vec("k9_release", '{16'h0000, 3, 0, 4'd9, 1'b0});

    // Continuous tick with key 4 held.
    keys = 16'h0010;
    p0 = pulses;
    #1 i_tick = 1'b1;
    repeat (200) @(posedge i_clk);
    #1 i_tick = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("fast_tick_pulses_le1", 32'(pulses - p0 > 1), 32'd0);
    keys = 16'h0000;
    run_frames(4);
    chk("fast_recover_idle", 32'(o_key_held), 32'd0);
    run_vec("fast_k4", '{16'h0010, 4, 1, 4'd4, 1'b1});
    keys = 16'h0000;
    run_frames(4);

    // Random keys, tick spacing (including back-to-back) and occasional resets.
    for (int seg = 0; seg < 80; seg++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 4) keys = 16'h0000;
      else if (sel < 8) keys = 16'h0001 << $urandom_range(0, 15);
      else if (sel == 8) keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      for (int t = int'($urandom_range(4, 24)); t > 0; t--) tick_after(int'($urandom_range(0, 5)));
      if ($urandom_range(0, 19) == 0) begin
        #1 i_rst_l = 1'b0;
        repeat (int'($urandom_range(1, 2))) @(posedge i_clk);
        #1 i_rst_l = 1'b1;
      end
    end
    repeat (3) @(posedge i_clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter DEBOUNCE_FRAMES, default 3, the number of consecutive identical scan frames required to accept a key-map change (legal range 1..15).
REQ-002 SHALL have port i_clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst_l  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port i_tick  input  1  scan-rate strobe, one i_clk cycle wide; advances the column.
REQ-005 SHALL have port i_row_l  input  4  keypad row lines, active low, asynchronous to i_clk.
REQ-006 SHALL have port o_col_l  output  4  keypad column drive, active low, walking zero.
REQ-007 SHALL have port o_key  output  4  code of the last accepted key, 4*row+col.
REQ-008 SHALL have port o_key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 SHALL have port o_key_held  output  1  high while the accepted key remains pressed.

Function
REQ-010 SHALL pass i_row_l through a 2-flop synchronizer before any use.
REQ-011 SHALL rotate o_col_l left by one position on each cycle with i_tick=1, giving the sequence 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-012 SHALL, on a cycle with i_tick=1, sample the synchronized rows for the currently driven column before rotating; row r low while column c is low sets key-map bit 4*r+c.
REQ-013 SHALL close a frame on the tick that samples column 3; the completed 16-bit map SHALL then be compared with the previous frame's map.
REQ-014 SHALL increment a stable-frame counter, saturating at DEBOUNCE_FRAMES, when the maps are equal, and SHALL load 1 when they differ.
REQ-015 SHALL treat the map as debounced when the stable count equals DEBOUNCE_FRAMES.
REQ-016 SHALL implement FSM states IDLE, PRESSED and LOCKED.
REQ-017 In IDLE, on a debounced map with exactly one bit set, the FSM SHALL go to PRESSED, load o_key with that bit index, and pulse o_key_valid in the cycle after the frame-closing tick.
REQ-018 In IDLE, on a debounced map with two or more bits set, the FSM SHALL go to LOCKED with no pulse and no o_key change.
REQ-019 In PRESSED or LOCKED, on a debounced all-zero map, the FSM SHALL return to IDLE; any other map SHALL hold the state with no pulse.
REQ-020 o_key_held SHALL equal 1 only in PRESSED; o_key SHALL retain its value until the next accepted key.
REQ-021 o_key_valid SHALL never be high for two consecutive cycles and SHALL pulse at most once per IDLE->PRESSED transition.
REQ-022 Behaviour SHALL be defined for ticks closer than 3 cycles apart, with no hang or X; sampled data may be stale in that case.

Reset
REQ-023 While i_rst_l=0 at a clock edge, the block SHALL set o_col_l=1110, o_key=0, o_key_valid=0, o_key_held=0, FSM=IDLE, stable count=0, previous map=0, synchronizer flops=1111, and the frame accumulator=0.
REQ-024 Reset mid-press SHALL abandon the press; a key still held after reset SHALL be re-detected and pulsed as a new key after debounce.

Structure
REQ-025 A shared package SHALL hold NUM_ROWS=4, NUM_COLS=4, COL_RESET=4'b1110, and the FSM state encodings.
REQ-026 The row synchronizer SHALL be a separate sub-module named row_sync, 4 bits wide, with a reset value of 1111.

Verification
REQ-027 Reset, then 8 ticks -> o_col_l = 1110, 1101, 1011, 0111, 1110, 1101, 1011, 0111; all other outputs 0.
REQ-028 Hold row1/col2 for 6 frames -> exactly one o_key_valid pulse after frame 3 closes, o_key=6, and o_key_held=1; release -> o_key_held=0 after 3 empty frames, with no second pulse.
REQ-029 Toggle row0/col0 every frame for 6 frames, then hold it -> no pulse during toggling; one pulse with o_key=0 after 3 stable frames.
REQ-030 Hold keys 0 and 5 together -> LOCKED with no pulse; release then press row3/col3 -> one pulse with o_key=15.
REQ-031 Press key 9, wait for its pulse, then pull i_rst_l low for 2 cycles while the key is still held -> outputs go to reset values; one new pulse with o_key=9 after 3 frames.
REQ-032 Hold i_tick=1 continuously with key 4 pressed -> no X on outputs, o_key_valid pulses no more than once, and no lockup.
